// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator back end (cic_decim_tail).
//
// Contents:
//   clog2       - ceiling log2 usable in constant expressions
//   cnt_width   - width of the valid-sample counter in the downsampler
//   CicR*/CicN* - default values used by the top-level parameters
package cic_pkg;

  localparam int unsigned CicDwDefault     = 32;
  localparam int unsigned CicRateDwDefault = 32;
  localparam int unsigned CicRDefault      = 10;
  localparam int unsigned CicNDefault      = 7;
  localparam int unsigned CicMDefault      = 1;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // A run-time ratio can be anything RATE_DW bits can hold, so the counter must
  // span the full rate width. A fixed ratio only needs to reach CIC_R-1.
  // Never narrower than one bit so the counter stays a legal vector.
  function automatic int unsigned cnt_width(input int unsigned rate_dw,
                                            input int unsigned cic_r,
                                            input bit          var_rate);
    int unsigned w;
    if (var_rate) begin
      w = rate_dw;
    end else begin
      w = clog2(cic_r);
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cic_decim_tail_comb.sv
// One CIC comb stage: y = x - x delayed by CIC_M input strobes.
//
// The delay line advances only when valid_i is high, so the differential delay
// is counted in samples, not clock cycles. Output data and strobe are both
// registered; the subtraction wraps modulo 2^DW.
//
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset
//   valid_i  in   input sample strobe
//   data_i   in   DW-bit two's-complement input sample
//   valid_o  out  output strobe, valid_i delayed by one cycle
//   data_o   out  DW-bit comb result, updated on each input strobe
module cic_decim_tail_comb #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CIC_M = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  // dly_q[0] is the most recent past sample, dly_q[CIC_M-1] the oldest.
  logic [CIC_M-1:0][DW-1:0] dly_q, dly_d;
  logic [DW-1:0]            data_q, data_d;
  logic                     valid_q, valid_d;

  always_comb begin
    dly_d   = dly_q;
    data_d  = data_q;
    valid_d = valid_i;
    if (valid_i) begin
      data_d   = data_i - dly_q[CIC_M-1];
      dly_d[0] = data_i;
      for (int unsigned i = 1; i < CIC_M; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dly_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dly_q   <= dly_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/cic_decim_tail.sv
// Decimating back end of the CIC decimator.
//
// Keeps one of every R valid integrator samples, runs the survivors through
// CIC_N comb stages (differential delay CIC_M) and registers the OUT_DW MSBs
// of the last comb result as a single-cycle-strobe stream. No back-pressure:
// every input strobe is consumed.
//
// Latency from the R-th valid input to m_axis_out_tvalid is CIC_N + 2 cycles
// (downsampler register, CIC_N comb registers, output register).
//
// Build option:
//   VARIABLE_RATE_EN  defined   - rate register loaded from s_axis_rate_*,
//                                 reset value CIC_R.
//                     undefined - ratio fixed at CIC_R, s_axis_rate_* ignored.
//
// Ports:
//   clk                 in   clock, rising edge
//   reset_n             in   synchronous active-low reset
//   s_axis_in_tdata     in   DW-bit signed integrator output
//   s_axis_in_tvalid    in   input sample strobe
//   s_axis_rate_tdata   in   RATE_DW-bit unsigned decimation ratio
//   s_axis_rate_tvalid  in   rate load strobe
//   m_axis_out_tdata    out  OUT_DW-bit signed decimated result (OUT_DW <= DW)
//   m_axis_out_tvalid   out  one-cycle output strobe
module cic_decim_tail
  import cic_pkg::*;
#(
  parameter int unsigned DW      = CicDwDefault,
  parameter int unsigned OUT_DW  = 32,
  parameter int unsigned RATE_DW = CicRateDwDefault,
  parameter int unsigned CIC_R   = CicRDefault,
  parameter int unsigned CIC_N   = CicNDefault,
  parameter int unsigned CIC_M   = CicMDefault
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DW-1:0]      s_axis_in_tdata,
  input  logic               s_axis_in_tvalid,
  input  logic [RATE_DW-1:0] s_axis_rate_tdata,
  input  logic               s_axis_rate_tvalid,
  output logic [OUT_DW-1:0]  m_axis_out_tdata,
  output logic               m_axis_out_tvalid
);

`ifdef VARIABLE_RATE_EN
  localparam bit VarRate = 1'b1;
`else
  localparam bit VarRate = 1'b0;
`endif

  localparam int unsigned CntW = cnt_width(RATE_DW, CIC_R, VarRate);

  // ---------------------------------------------------------------------------
  // Downsampler
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   ds_data_q, ds_data_d;
  logic            ds_valid_q, ds_valid_d;

  logic in_take;    // input strobe that counts toward the ratio
  logic hit;        // counter sits on the last sample of a frame
  logic rate_load;  // counter restart request

`ifdef VARIABLE_RATE_EN
  logic [RATE_DW-1:0] rate_q, rate_d;
  logic [RATE_DW-1:0] rate_last;

  always_comb begin
    rate_d = rate_q;
    if (s_axis_rate_tvalid) begin
      rate_d = s_axis_rate_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rate_q <= RATE_DW'(CIC_R);
    end else begin
      rate_q <= rate_d;
    end
  end

  assign rate_last = rate_q - RATE_DW'(1);
  assign rate_load = s_axis_rate_tvalid;
  // A sample arriving in the load cycle belongs to neither the old nor the
  // new ratio, so it is dropped.
  assign in_take   = s_axis_in_tvalid & ~s_axis_rate_tvalid;
  // Ratios 0 and 1 both mean "pass everything".
  assign hit       = (rate_q <= RATE_DW'(1)) | (cnt_q == rate_last);
`else
  localparam logic [CntW-1:0] LastCnt = (CIC_R > 1) ? CntW'(CIC_R - 1) : '0;

  logic unused_rate;
  assign unused_rate = ^{s_axis_rate_tdata, s_axis_rate_tvalid};

  assign rate_load = 1'b0;
  assign in_take   = s_axis_in_tvalid;
  assign hit       = (CIC_R <= 1) || (cnt_q == LastCnt);
`endif

  always_comb begin
    cnt_d      = cnt_q;
    ds_data_d  = ds_data_q;
    ds_valid_d = 1'b0;
    if (rate_load) begin
      cnt_d = '0;
    end else if (in_take) begin
      if (hit) begin
        cnt_d      = '0;
        ds_valid_d = 1'b1;
        ds_data_d  = s_axis_in_tdata;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comb chain: stage k reads stg_*[k] and drives stg_*[k+1]
  // ---------------------------------------------------------------------------
  logic [CIC_N:0] stg_valid;
  logic [DW-1:0]  stg_data [CIC_N+1];

  assign stg_valid[0] = ds_valid_q;
  assign stg_data[0]  = ds_data_q;

  for (genvar k = 0; k < CIC_N; k++) begin : g_comb
    cic_decim_tail_comb #(
      .DW    (DW),
      .CIC_M (CIC_M)
    ) u_comb (
      .clk     (clk),
      .reset_n (reset_n),
      .valid_i (stg_valid[k]),
      .data_i  (stg_data[k]),
      .valid_o (stg_valid[k+1]),
      .data_o  (stg_data[k+1])
    );
  end

  // ---------------------------------------------------------------------------
  // Output register: keep the OUT_DW MSBs of the last comb result
  // ---------------------------------------------------------------------------
  logic [DW-1:0]     comb_last;
  logic [OUT_DW-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  assign comb_last = stg_data[CIC_N];

  // Truncated LSBs are intentionally discarded.
  logic [DW-1:0] unused_comb_last;
  assign unused_comb_last = comb_last;

  always_comb begin
    out_valid_d = stg_valid[CIC_N];
    out_data_d  = out_data_q;
    if (stg_valid[CIC_N]) begin
      out_data_d = comb_last[DW-1 -: OUT_DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      ds_data_q   <= '0;
      ds_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ds_data_q   <= ds_data_d;
      ds_valid_q  <= ds_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign m_axis_out_tdata  = out_data_q;
  assign m_axis_out_tvalid = out_valid_q;

endmodule

// File: tb/tb_cic_decim_tail.sv
// Bench for cic_decim_tail.
// DUT A: DW=OUT_DW=16, N=2, M=1, R=4 (rate-load behaviour follows VARIABLE_RATE_EN).
// DUT B: DW=16, OUT_DW=8, N=1, M=2, R=1 (MSB truncation and wrap-around).
module tb_cic_decim_tail;

  localparam int LatA = 2 + 2;
  localparam int LatB = 1 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] a_in;
  logic        a_vld;
  logic [31:0] a_rate;
  logic        a_rate_vld;
  logic [15:0] a_out;
  logic        a_out_vld;
  logic [15:0] b_in;
  logic        b_vld;
  logic [7:0]  b_rate;
  logic        b_rate_vld;
  logic [7:0]  b_out;
  logic        b_out_vld;

  cic_decim_tail #(
    .DW(16), .OUT_DW(16), .RATE_DW(32), .CIC_R(4), .CIC_N(2), .CIC_M(1)
  ) u_dut_a (
    .clk                (clk),
    .reset_n            (reset_n),
    .s_axis_in_tdata    (a_in),
    .s_axis_in_tvalid   (a_vld),
    .s_axis_rate_tdata  (a_rate),
    .s_axis_rate_tvalid (a_rate_vld),
    .m_axis_out_tdata   (a_out),
    .m_axis_out_tvalid  (a_out_vld)
  );

  cic_decim_tail #(
    .DW(16), .OUT_DW(8), .RATE_DW(8), .CIC_R(1), .CIC_N(1), .CIC_M(2)
  ) u_dut_b (
    .clk                (clk),
    .reset_n            (reset_n),
    .s_axis_in_tdata    (b_in),
    .s_axis_in_tvalid   (b_vld),
    .s_axis_rate_tdata  (b_rate),
    .s_axis_rate_tvalid (b_rate_vld),
    .m_axis_out_tdata   (b_out),
    .m_axis_out_tvalid  (b_out_vld)
  );

  typedef struct {
    bit          tgt;   // 0: DUT A, 1: DUT B
    logic [15:0] din;
    logic        vld;
    logic [31:0] rate;
    logic        rvld;
    bit          push;  // this input completes a frame -> expect an output
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  vec_t vecs[$];
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboards: every output strobe must match the oldest pending expectation
  // in both value and arrival cycle.
  always @(negedge clk) begin
    if (a_out_vld === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_spurious_out", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        check("a_data", {16'h0, a_out}, {16'h0, ea.data});
        check("a_cycle", cyc, ea.due);
      end
    end
    if (b_out_vld === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_spurious_out", 32'd1, 32'd0);
      end else begin
        eb = qb.pop_front();
        check("b_data", {24'h0, b_out}, {16'h0, eb.data});
        check("b_cycle", cyc, eb.due);
      end
    end
  end

  function automatic void add(bit tgt, logic [15:0] din, logic vld, logic [31:0] rate,
                              logic rvld, bit push, logic [15:0] exp);
    vecs.push_back('{tgt, din, vld, rate, rvld, push, exp});
  endfunction

  task automatic idle_inputs();
    a_vld = 1'b0; a_rate_vld = 1'b0; b_vld = 1'b0; b_rate_vld = 1'b0;
  endtask

  task automatic apply();
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      idle_inputs();
      if (vecs[i].tgt == 1'b0) begin
        a_in = vecs[i].din; a_vld = vecs[i].vld;
        a_rate = vecs[i].rate; a_rate_vld = vecs[i].rvld;
        if (vecs[i].push) qa.push_back('{vecs[i].exp, cyc + LatA});
      end else begin
        b_in = vecs[i].din; b_vld = vecs[i].vld;
        b_rate = vecs[i].rate[7:0]; b_rate_vld = vecs[i].rvld;
        if (vecs[i].push) qb.push_back('{vecs[i].exp, cyc + LatB});
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    vecs.delete();
  endtask

  // Bounded wait for pending outputs; anything still queued never arrived.
  task automatic drain(input string name);
    repeat (8) @(posedge clk);
    #1;
    check({name, "_a_pending"}, qa.size(), 32'd0);
    check({name, "_b_pending"}, qb.size(), 32'd0);
    qa.delete();
    qb.delete();
  endtask

  // One-cycle reset with live input strobes, which must be ignored.
  task automatic do_reset(input string name);
    @(posedge clk); #1;
    reset_n = 1'b0;
    a_vld = 1'b1; a_in = 16'h0055; b_vld = 1'b1; b_in = 16'h0055;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_inputs();
    check({name, "_a_vld"}, {31'h0, a_out_vld}, 32'd0);
    check({name, "_a_data"}, {16'h0, a_out}, 32'd0);
    check({name, "_b_vld"}, {31'h0, b_out_vld}, 32'd0);
    check({name, "_b_data"}, {24'h0, b_out}, 32'd0);
  endtask

  logic [15:0] exp_const [4];
  logic [15:0] exp_ramp  [4];
  logic [15:0] b_din     [7];
  logic [15:0] b_exp     [7];

  initial begin
    exp_const = '{16'h0001, 16'hFFFF, 16'h0000, 16'h0000};
    exp_ramp  = '{16'h0003, 16'h0001, 16'h0000, 16'h0000};
    b_din = '{16'h1234, 16'h0000, 16'h8000, 16'h0000, 16'h7000, 16'h0001, 16'h00FF};
    b_exp = '{16'h0012, 16'h0000, 16'h006D, 16'h0000, 16'h00F0, 16'h0000, 16'h0090};

    reset_n = 1'b0;
    a_in = '0; a_rate = '0; b_in = '0; b_rate = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    do_reset("por");

    // Constant 1 every cycle: 1, -1, 0, 0 on every 4th sample.
    for (int i = 0; i < 16; i++) add(0, 16'd1, 1, 0, 0, (i % 4) == 3, exp_const[i / 4]);
    apply();
    drain("const");

    // Ramp: downsampled 3, 7, 11, 15 -> 3, 1, 0, 0.
    do_reset("rst_ramp");
    for (int i = 0; i < 16; i++) add(0, 16'(i), 1, 0, 0, (i % 4) == 3, exp_ramp[i / 4]);
    apply();
    drain("ramp");

    // Same ramp with tvalid toggling: same values, outputs 8 cycles apart.
    do_reset("rst_gap");
    for (int i = 0; i < 16; i++) begin
      add(0, 16'(i), 1, 0, 0, (i % 4) == 3, exp_ramp[i / 4]);
      add(0, 16'hDEAD, 0, 0, 0, 0, 16'h0);
    end
    apply();
    drain("gap");

    // Truncation to 8 MSBs and modulo wrap, one output per cycle.
    do_reset("rst_b");
    for (int i = 0; i < 7; i++) add(1, b_din[i], 1, 0, 0, 1, b_exp[i]);
    apply();
    drain("trunc");

    do_reset("rst_rate");
`ifdef VARIABLE_RATE_EN
    // Load rate=2 mid-frame; the sample in the load cycle is dropped.
    add(0, 16'd10, 1, 0, 0, 0, 16'h0);
    add(0, 16'd11, 1, 0, 0, 0, 16'h0);
    add(0, 16'd99, 1, 32'd2, 1, 0, 16'h0);
    add(0, 16'd20, 1, 0, 0, 0, 16'h0);
    add(0, 16'd21, 1, 0, 0, 1, 16'd21);
    add(0, 16'd22, 1, 0, 0, 0, 16'h0);
    add(0, 16'd23, 1, 0, 0, 1, 16'hFFED);
    add(0, 16'd0,  0, 32'd0, 1, 0, 16'h0);
    add(0, 16'd30, 1, 0, 0, 1, 16'd5);
    add(0, 16'd31, 1, 0, 0, 1, 16'hFFFA);
    add(0, 16'd0,  0, 32'd1, 1, 0, 16'h0);
    add(0, 16'd32, 1, 0, 0, 1, 16'd0);
`else
    // Fixed build: rate strobes are ignored and do not drop samples.
    add(0, 16'd10, 1, 32'd2, 1, 0, 16'h0);
    add(0, 16'd11, 1, 32'd2, 1, 0, 16'h0);
    add(0, 16'd12, 1, 32'd2, 1, 0, 16'h0);
    add(0, 16'd13, 1, 32'd2, 1, 1, 16'd13);
`endif
    apply();
    drain("rate");

    // Reset mid-frame: counter, history and rate all return to defaults.
    do_reset("rst_mid0");
    for (int i = 0; i < 4; i++) add(0, 16'd5, 1, 0, 0, i == 3, 16'd5);
    add(0, 16'd9, 1, 0, 0, 0, 16'h0);
    add(0, 16'd9, 1, 0, 0, 0, 16'h0);
    apply();
    drain("mid_pre");
    do_reset("rst_mid");
    for (int i = 0; i < 4; i++) add(0, 16'd7, 1, 0, 0, i == 3, 16'd7);
    apply();
    drain("mid_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
